// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer game engine.
package reaction_pkg;

    localparam int unsigned RESULT_W = 28;
    localparam logic [RESULT_W-1:0] RESULT_NONE = 28'hFFFFFFF;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_WAIT  = 3'b001,
        ST_GO    = 3'b010,
        ST_LATE  = 3'b011,
        ST_EARLY = 3'b110,
        ST_HIT   = 3'b100
    } state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1; never maps a non-zero value to 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/reaction_input.sv
// Button input path: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Debounce is built only when REACTION_DEBOUNCE_EN is defined.
module reaction_input
    import reaction_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_d;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

`ifdef REACTION_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] stable_cnt;

    // The level follows sync2 only after sync2 has differed from it for DEBOUNCE_CYCLES edges in a row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level      <= sync2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync2;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_d <= 1'b0;
            o_press <= 1'b0;
        end else begin
            sync1   <= i_btn;
            sync2   <= sync1;
            level_d <= level;
            o_press <= level & ~level_d;
        end
    end

endmodule

// File: rtl/reaction_core.sv
// Reaction-timer round engine: press input, LFSR, tick prescaler, round FSM, last/best results.
// Optional button debounce is selected with REACTION_DEBOUNCE_EN.
module reaction_core
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 1,
    parameter int unsigned MIN_DELAY       = 1000,
    parameter logic [15:0] RND_MASK        = 16'h0FFF,
    parameter int unsigned TIMEOUT         = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_btn,
    input  logic                i_clr_best,
    output logic [2:0]          o_reaction_state,
    output logic [RESULT_W-1:0] o_last_result,
    output logic [RESULT_W-1:0] o_best_result,
    output logic [15:0]         o_dbg_rnd
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [RESULT_W-1:0] TIMEOUT_V   = RESULT_W'(TIMEOUT);
    localparam logic [RESULT_W-1:0] MIN_DELAY_V = RESULT_W'(MIN_DELAY);

    if (TIMEOUT >= (1 << RESULT_W) - 1) begin : g_bad_timeout
        $error("TIMEOUT must be below the untracked result value");
    end

    state_t              state;
    logic                press;
    logic                tick;
    logic [PRE_W-1:0]    pre_cnt;
    logic [15:0]         lfsr;
    logic [RESULT_W-1:0] delay;
    logic [RESULT_W-1:0] react_cnt;
    logic [RESULT_W-1:0] last_result;
    logic [RESULT_W-1:0] best_result;
    logic [RESULT_W-1:0] load_delay;
    logic [RESULT_W-1:0] cnt_now;

    reaction_input #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_input (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_btn  (i_btn),
        .o_press(press)
    );

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // cnt_now includes the current tick, so a press on the TIMEOUT tick still reports TIMEOUT as a HIT.
    always_comb begin
        load_delay = MIN_DELAY_V + RESULT_W'(lfsr & RND_MASK);
        cnt_now    = react_cnt;
        if (tick && (react_cnt != TIMEOUT_V)) begin
            cnt_now = react_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            delay       <= '0;
            react_cnt   <= '0;
            last_result <= RESULT_NONE;
            best_result <= RESULT_NONE;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (press) begin
                        state       <= ST_EARLY;
                        last_result <= RESULT_NONE;
                    end else if (tick) begin
                        if (delay <= RESULT_W'(1)) begin
                            state     <= ST_GO;
                            react_cnt <= '0;
                        end else begin
                            delay <= delay - 1'b1;
                        end
                    end
                end
                ST_GO: begin
                    react_cnt <= cnt_now;
                    if (press) begin
                        state       <= ST_HIT;
                        last_result <= cnt_now;
                        if (cnt_now < best_result) begin
                            best_result <= cnt_now;
                        end
                    end else if (cnt_now == TIMEOUT_V) begin
                        state       <= ST_LATE;
                        last_result <= RESULT_NONE;
                    end
                end
                default: begin
                    if (press) begin
                        state <= ST_WAIT;
                        delay <= load_delay;
                    end
                end
            endcase
            if (i_clr_best) begin
                best_result <= RESULT_NONE;
            end
        end
    end

    assign o_reaction_state = state;
    assign o_last_result    = last_result;
    assign o_best_result    = best_result;
    assign o_dbg_rnd        = lfsr;

endmodule

// File: tb/tb_reaction_core.sv
// Self-checking bench for reaction_core: time-stamp based round model plus directed literal checks.
// Build with REACTION_DEBOUNCE_EN defined to exercise the debounced input path.
module tb_reaction_core;

    localparam int unsigned TIMEOUT  = 50;
    localparam logic [15:0] RND_MASK = 16'h0000;
    localparam logic [27:0] NONE     = 28'hFFFFFFF;
    localparam int unsigned DEB      = 16;
`ifdef REACTION_DEBOUNCE_EN
    localparam int unsigned LAT       = 3 + DEB;
    localparam int unsigned MIN_DELAY = 80;
`else
    localparam int unsigned LAT       = 3;
    localparam int unsigned MIN_DELAY = 10;
`endif
    localparam int unsigned HOLD = LAT + 2;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_WAIT  = 3'b001;
    localparam logic [2:0] S_GO    = 3'b010;
    localparam logic [2:0] S_LATE  = 3'b011;
    localparam logic [2:0] S_EARLY = 3'b110;
    localparam logic [2:0] S_HIT   = 3'b100;

    logic        clk;
    logic        rst_n;
    logic        btn;
    logic        clr;
    logic [2:0]  state;
    logic [27:0] last;
    logic [27:0] best;
    logic [15:0] rnd;

    int n_tests = 0;
    int n_fail  = 0;

    reaction_core #(
        .TICK_DIV       (1),
        .MIN_DELAY      (MIN_DELAY),
        .RND_MASK       (RND_MASK),
        .TIMEOUT        (TIMEOUT),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_btn           (btn),
        .i_clr_best      (clr),
        .o_reaction_state(state),
        .o_last_result   (last),
        .o_best_result   (best),
        .o_dbg_rnd       (rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Rounds are tracked by absolute edge numbers: GO begins at a known edge,
    // and the reaction count is simply the number of edges since then.
    logic [2:0]      m_state;
    logic [27:0]     m_last;
    logic [27:0]     m_best;
    logic [15:0]     m_lfsr;
    logic [DEB+3:0]  smp;
    logic            m_press;
    logic            m_level;
    logic            m_level_d;
    int unsigned     m_cyc;
    int unsigned     m_go_at;
    int unsigned     m_go_start;

    task automatic model_reset();
        m_state   = S_IDLE;
        m_last    = NONE;
        m_best    = NONE;
        m_lfsr    = 16'hACE1;
        smp       = '0;
        m_press   = 1'b0;
        m_level   = 1'b0;
        m_level_d = 1'b0;
        m_cyc     = 0;
        m_go_at   = 0;
        m_go_start = 0;
    endtask

    task automatic model_step();
        logic        pr;
        int unsigned cnt;
        pr = m_press;
        m_cyc++;
        smp = {smp[DEB+2:0], btn};
`ifdef REACTION_DEBOUNCE_EN
        begin
            bit all_eq;
            all_eq = 1'b1;
            for (int j = 3; j <= DEB + 1; j++) if (smp[j] !== smp[2]) all_eq = 1'b0;
            m_press   = m_level & ~m_level_d;
            m_level_d = m_level;
            if (all_eq && (smp[2] != m_level)) m_level = smp[2];
        end
`else
        m_press = smp[2] & ~smp[3];
`endif
        case (m_state)
            S_WAIT: begin
                if (pr) begin
                    m_state = S_EARLY;
                    m_last  = NONE;
                end else if (m_cyc == m_go_at) begin
                    m_state    = S_GO;
                    m_go_start = m_cyc;
                end
            end
            S_GO: begin
                cnt = m_cyc - m_go_start;
                if (cnt > TIMEOUT) cnt = TIMEOUT;
                if (pr) begin
                    m_state = S_HIT;
                    m_last  = 28'(cnt);
                    if (28'(cnt) < m_best) m_best = 28'(cnt);
                end else if (cnt == TIMEOUT) begin
                    m_state = S_LATE;
                    m_last  = NONE;
                end
            end
            default: begin
                if (pr) begin
                    m_state = S_WAIT;
                    m_go_at = m_cyc + MIN_DELAY + int'(m_lfsr & RND_MASK);
                end
            end
        endcase
        if (clr) m_best = NONE;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("state", 32'(state), 32'(m_state));
                check("last", 32'(last), 32'(m_last));
                check("best", 32'(best), 32'(m_best));
                check("rnd", 32'(rnd), 32'(m_lfsr));
                n_tests++;
                if (rnd == 16'h0000) begin
                    n_fail++;
                    $display("FAIL rnd_zero: got %0h required non-zero", rnd);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press();
        btn = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n;
        n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(state), 32'(st));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    // Press so that the HIT lands on the r-th tick of GO; optionally clear best on that same edge.
    task automatic hit_round(input int unsigned r, input bit with_clr);
        press();
        wait_state(S_GO, MIN_DELAY + 4 * HOLD + 40, "round_go");
        repeat (r - LAT - 1) @(negedge clk);
        fork
            press();
            begin
                repeat (LAT) @(negedge clk);
                clr = with_clr;
                @(negedge clk);
                clr = 1'b0;
            end
        join
        check("hit_state", 32'(state), 32'(S_HIT));
        check("hit_last", 32'(last), 32'(r));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int hold;
        rst_n = 1'b0;
        btn   = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_last", 32'(last), 32'(NONE));
        check("rst_best", 32'(best), 32'(NONE));
        check("rst_rnd", 32'(rnd), 32'h0000ACE1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First HIT: 23 ticks after GO entry
        hit_round(23, 1'b0);
        check("s1_best", 32'(best), 32'd23);

        // Second press lands on the edge the delay expires: early wins
        press();
        check("s2_wait", 32'(state), 32'(S_WAIT));
        press();
        wait_state(S_EARLY, 4 * HOLD + MIN_DELAY, "s2_early");
        check("s2_last", 32'(last), 32'(NONE));
        check("s2_best", 32'(best), 32'd23);

        // No press in GO: LATE exactly TIMEOUT ticks after GO entry
        press();
        wait_state(S_GO, MIN_DELAY + 4 * HOLD + 40, "s3_go");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state == S_GO && n < 200);
        check("s3_late_ticks", 32'(n), 32'd50);
        check("s3_state", 32'(state), 32'(S_LATE));
        check("s3_last", 32'(last), 32'(NONE));

        // Press latency from a terminal state
        btn = 1'b1;
        n = 0;
        while (state == S_LATE && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("press_latency", 32'(n), 32'(LAT + 1));
        repeat (HOLD) @(negedge clk);
        btn = 1'b0;
        wait_state(S_LATE, MIN_DELAY + TIMEOUT + 4 * HOLD + 20, "s3_relate");

`ifdef REACTION_DEBOUNCE_EN
        btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_ignored", 32'(state), 32'(S_LATE));
`endif

        // Best tracking and clear
        pulse_clr();
        check("clr_best", 32'(best), 32'(NONE));
        hit_round(40, 1'b0);
        check("best_40", 32'(best), 32'd40);
        hit_round(20, 1'b0);
        check("best_20", 32'(best), 32'd20);
        hit_round(30, 1'b0);
        check("best_keep20", 32'(best), 32'd20);
        hit_round(35, 1'b1);
        check("clr_wins", 32'(best), 32'(NONE));
        hit_round(30, 1'b0);
        check("best_30", 32'(best), 32'd30);
        hit_round(TIMEOUT, 1'b0);
        check("hit_at_timeout_best", 32'(best), 32'd30);
        pulse_clr();
        check("clr_best2", 32'(best), 32'(NONE));

        // Asynchronous reset in the middle of GO
        press();
        wait_state(S_GO, MIN_DELAY + 4 * HOLD + 40, "s5_go");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'(S_IDLE));
        check("arst_last", 32'(last), 32'(NONE));
        check("arst_best", 32'(best), 32'(NONE));
        check("arst_rnd", 32'(rnd), 32'h0000ACE1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized play against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn  = ~btn;
                hold = $urandom_range(1, 45);
            end
            hold--;
            clr = ($urandom_range(0, 31) == 0);
            if (i == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        btn = 1'b0;
        clr = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
